bin_to_bcd_seq: RTL and testbench
=================================

BIN_TO_BCD_SEQ -- requirements
Module: bin_to_bcd_seq

Interface
REQ-001 Parameter BIN_W, default 9: binary input width; legal range 1..32.
REQ-002 Parameter DIGITS, default 4: number of BCD digits produced; legal range 1..10.
REQ-003 sys_clk  input  1  single clock; all state updates on its rising edge.
REQ-004 sys_rst_n  input  1  reset, synchronous and active-low.
REQ-005 in_valid  input  1  bin_in holds a value to convert.
REQ-006 in_ready  output  1  block can accept a value this cycle.
REQ-007 bin_in  input  BIN_W  unsigned binary value.
REQ-008 out_valid  output  1  bcd_out, blank_mask and ovf hold a result.
REQ-009 out_ready  input  1  consumer takes the result this cycle.
REQ-010 bcd_out  output  4*DIGITS  result nibbles {digit DIGITS-1 (MSD), ..., digit 0 (units)}.
REQ-011 blank_mask  output  DIGITS  bit i high = digit i is a leading zero, for seven-segment blanking.
REQ-012 ovf  output  1  input exceeded 10^DIGITS-1; result saturated.
REQ-013 busy  output  1  high in SHIFT or DONE.

Function
REQ-014 FSM states IDLE, SHIFT, DONE; reset state IDLE.
REQ-015 in_ready SHALL be high exactly in IDLE; out_valid exactly in DONE; no combinational path from in_valid or out_ready to any output.
REQ-016 IDLE with in_valid high: on that edge, capture bin_in into a shift register, clear BCD accumulator, load a shift counter with BIN_W, compute ovf = (bin_in > 10^DIGITS-1), go to SHIFT.
REQ-017 SHIFT, each cycle: every BCD nibble >= 5 gets +3, then the {accumulator, shift register} pair shifts left 1 bit (MSB of bin first); counter decrements.
REQ-018 Counter reaching its final shift: go to DONE on that edge; out_valid SHALL rise exactly BIN_W cycles after the accepting edge.
REQ-019 DONE: bcd_out, blank_mask, ovf held stable while out_valid high and out_ready low (unbounded backpressure).
REQ-020 DONE with out_ready high: go to IDLE on that edge; next acceptance earliest on the following edge; one conversion per BIN_W+2 cycles at full rate.
REQ-021 ovf high: bcd_out SHALL be all digits 9 (4'h9 each), blank_mask all zeros, regardless of accumulator contents.
REQ-022 blank_mask: bit i (i >= 1) high iff digit i and all digits above it are zero; bit 0 always low, so value 0 shows a single "0".
REQ-023 Every output nibble SHALL be in 0..9 for any bin_in.
REQ-024 in_valid in SHIFT or DONE is ignored; bin_in changes after acceptance do not affect the result.
REQ-025 Outputs bcd_out, blank_mask, ovf are registered; their values outside DONE are the last result (zero after reset) and carry no meaning.

Reset
REQ-026 sys_rst_n low at an edge: state IDLE, in_ready 1, out_valid 0, busy 0, bcd_out 0, blank_mask 0, ovf 0, counter and shift registers 0.
REQ-027 Reset during SHIFT or DONE SHALL abort the conversion with no result presented; reset takes priority over in_valid and out_ready on the same edge.
REQ-028 First acceptance possible on the first edge with sys_rst_n high.

Verification
REQ-029 BIN_W=9, DIGITS=4, out_ready tied 1: bin_in 0 -> bcd_out 16'h0000, blank_mask 4'b1110, ovf 0, out_valid 9 cycles after acceptance for one cycle.
REQ-030 Same config: bin_in 511 -> 16'h0511, blank_mask 4'b1000; bin_in 100 -> 16'h0100, blank_mask 4'b1000; bin_in 7 -> 16'h0007, blank_mask 4'b1110.
REQ-031 BIN_W=9, DIGITS=2: bin_in 99 -> 8'h99, ovf 0; bin_in 100 -> 8'h99, ovf 1, blank_mask 2'b00.
REQ-032 Backpressure: out_ready low 20 cycles after out_valid -> outputs constant, in_ready 0, second in_valid ignored; out_ready high one cycle -> IDLE next edge.
REQ-033 Reset asserted at 4th SHIFT cycle -> next edge all outputs at reset values, no out_valid pulse; new input 42 then gives 16'h0042.
REQ-034 Exhaustive BIN_W=9, DIGITS=4: all 512 inputs with random in_valid/out_ready gaps, compare against a divide/modulo reference model.

Source files
------------

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one bit per clock,
// with saturation on overflow and leading-zero blanking for 7-segment drive.
//
// state | meaning
// IDLE  | waiting for in_valid; in_ready high
// SHIFT | double-dabble iterations, BIN_W cycles
// DONE  | result presented; out_valid high until out_ready
module bin_to_bcd_seq #(
  parameter int BIN_W  = 9,
  parameter int DIGITS = 4
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BIN_W-1:0]      bin_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic [DIGITS-1:0]     blank_mask,
  output logic                  ovf,
  output logic                  busy
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);

  function automatic logic [63:0] max_value(input int d);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < d; i++) p = p * 64'd10;
    return p - 64'd1;
  endfunction

  localparam logic [63:0]      MAX_VAL  = max_value(DIGITS);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BIN_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [BIN_W-1:0]    sr_q, sr_d;
  logic [BCD_W-1:0]    acc_q, acc_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                ovf_pend_q, ovf_pend_d;
  logic [BCD_W-1:0]    bcd_q, bcd_d;
  logic [DIGITS-1:0]   blank_q, blank_d;
  logic                ovf_q, ovf_d;

  logic [BCD_W-1:0]    acc_adj;
  logic [BCD_W-1:0]    acc_shift;
  logic [BCD_W-1:0]    res_bcd;
  logic [DIGITS-1:0]   res_blank;
  logic                zero_above;

  // One double-dabble step plus the result the final step would produce.
  always_comb begin
    acc_adj = acc_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (acc_q[4*i +: 4] >= 4'd5) acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
    end
    acc_shift = {acc_adj[BCD_W-2:0], sr_q[BIN_W-1]};

    res_bcd = ovf_pend_q ? {DIGITS{4'h9}} : acc_shift;

    res_blank  = '0;
    zero_above = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_above   = zero_above & (res_bcd[4*i +: 4] == 4'd0);
      res_blank[i] = zero_above;
    end
  end

  always_comb begin
    state_d    = state_q;
    sr_d       = sr_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    ovf_pend_d = ovf_pend_q;
    bcd_d      = bcd_q;
    blank_d    = blank_q;
    ovf_d      = ovf_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          sr_d       = bin_in;
          acc_d      = '0;
          cnt_d      = CNT_LOAD;
          ovf_pend_d = (64'(bin_in) > MAX_VAL);
          state_d    = SHIFT;
        end
      end
      SHIFT: begin
        sr_d  = sr_q << 1;
        acc_d = acc_shift;
        cnt_d = cnt_q - CNT_LAST;
        if (cnt_q == CNT_LAST) begin
          // Result registers load on the last shift so DONE presents them directly.
          bcd_d   = res_bcd;
          blank_d = res_blank;
          ovf_d   = ovf_pend_q;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q    <= IDLE;
      sr_q       <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      ovf_pend_q <= 1'b0;
      bcd_q      <= '0;
      blank_q    <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      sr_q       <= sr_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      ovf_pend_q <= ovf_pend_d;
      bcd_q      <= bcd_d;
      blank_q    <= blank_d;
      ovf_q      <= ovf_d;
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign out_valid  = (state_q == DONE);
  assign busy       = (state_q != IDLE);
  assign bcd_out    = bcd_q;
  assign blank_mask = blank_q;
  assign ovf        = ovf_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Scoreboard bench for bin_to_bcd_seq: a 4-digit instance (main checks) and
// a 2-digit instance (saturation checks), both with BIN_W = 9.
module tb_bin_to_bcd_seq;

  localparam int BIN_W = 9;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // 4-digit instance
  logic        in_valid4 = 1'b0;
  logic [8:0]  bin_in4 = '0;
  logic        in_ready4, out_valid4, out_ready4, ovf4, busy4;
  logic [15:0] bcd4;
  logic [3:0]  blank4;
  int          rdy_mode = 1;
  logic        rand_rdy = 1'b1;

  always @(negedge clk) rand_rdy = ($urandom_range(0, 3) != 0);
  assign out_ready4 = (rdy_mode == 2) ? rand_rdy : (rdy_mode == 1);

  bin_to_bcd_seq #(.BIN_W(BIN_W), .DIGITS(4)) u_dut4 (
    .sys_clk    (clk),
    .sys_rst_n  (rst_n),
    .in_valid   (in_valid4),
    .in_ready   (in_ready4),
    .bin_in     (bin_in4),
    .out_valid  (out_valid4),
    .out_ready  (out_ready4),
    .bcd_out    (bcd4),
    .blank_mask (blank4),
    .ovf        (ovf4),
    .busy       (busy4)
  );

  // 2-digit instance
  logic        in_valid2 = 1'b0;
  logic [8:0]  bin_in2 = '0;
  logic        in_ready2, out_valid2, out_ready2, ovf2, busy2;
  logic [7:0]  bcd2;
  logic [1:0]  blank2;

  assign out_ready2 = 1'b1;

  bin_to_bcd_seq #(.BIN_W(BIN_W), .DIGITS(2)) u_dut2 (
    .sys_clk    (clk),
    .sys_rst_n  (rst_n),
    .in_valid   (in_valid2),
    .in_ready   (in_ready2),
    .bin_in     (bin_in2),
    .out_valid  (out_valid2),
    .out_ready  (out_ready2),
    .bcd_out    (bcd2),
    .blank_mask (blank2),
    .ovf        (ovf2),
    .busy       (busy2)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference: divide/modulo digits, blanking from magnitude.
  function automatic void ref_model(input longint v, input int digits,
                                    output logic [39:0] bcd, output logic [9:0] blank,
                                    output logic ovf);
    longint p;
    longint pi;
    bcd   = '0;
    blank = '0;
    p = 1;
    for (int i = 0; i < digits; i++) p = p * 10;
    ovf = (v >= p);
    for (int i = 0; i < digits; i++) begin
      pi = 1;
      for (int j = 0; j < i; j++) pi = pi * 10;
      if (ovf) bcd[4*i +: 4] = 4'h9;
      else     bcd[4*i +: 4] = 4'((v / pi) % 10);
      blank[i] = (i >= 1) && !ovf && (v < pi);
    end
  endfunction

  typedef struct {
    logic [15:0] bcd;
    logic [3:0]  blank;
    logic        ovf;
    int          acc_edge;
  } exp_t;

  exp_t sb_q[$];

  task automatic push4(input int v);
    logic [39:0] b;
    logic [9:0]  bl;
    logic        o;
    exp_t        e;
    ref_model(v, 4, b, bl, o);
    e.bcd      = b[15:0];
    e.blank    = bl[3:0];
    e.ovf      = o;
    e.acc_edge = cyc + 1;
    sb_q.push_back(e);
  endtask

  // Monitor: latency on rising out_valid, result compare on handshake.
  logic prev_ov = 1'b0;
  logic hs_prev = 1'b0;
  exp_t mon_e;

  always @(negedge clk) begin
    #1;
    if (!rst_n) begin
      prev_ov = 1'b0;
      hs_prev = 1'b0;
    end else begin
      if (hs_prev) chk("out_valid_drop", out_valid4, 1'b0);
      if (out_valid4 && !prev_ov) begin
        if (sb_q.size() == 0) chk("spurious_out_valid", out_valid4, 1'b0);
        else chk("latency", cyc - sb_q[0].acc_edge, BIN_W);
      end
      hs_prev = out_valid4 && out_ready4;
      if (hs_prev && sb_q.size() != 0) begin
        mon_e = sb_q.pop_front();
        chk("bcd_out", bcd4, mon_e.bcd);
        chk("blank_mask", blank4, mon_e.blank);
        chk("ovf", ovf4, mon_e.ovf);
      end
      prev_ov = out_valid4;
    end
  end

  task automatic wait_ready4();
    int k;
    k = 0;
    while (!in_ready4 && k < 100) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic send4(input int v);
    wait_ready4();
    if (!in_ready4) begin
      chk("in_ready_wait", in_ready4, 1'b1);
      return;
    end
    in_valid4 = 1'b1;
    bin_in4   = 9'(v);
    push4(v);
    @(negedge clk);
    in_valid4 = 1'b0;
    bin_in4   = 9'($urandom);
  endtask

  task automatic stream4(input int n);
    int last;
    int v;
    last = 0;
    for (int i = 0; i < n; i++) begin
      wait_ready4();
      if (!in_ready4) begin
        chk("stream_ready_wait", in_ready4, 1'b1);
        break;
      end
      v = $urandom_range(0, 511);
      in_valid4 = 1'b1;
      bin_in4   = 9'(v);
      push4(v);
      if (i > 0) chk("full_rate_interval", cyc + 1 - last, BIN_W + 2);
      last = cyc + 1;
      @(negedge clk);
    end
    in_valid4 = 1'b0;
  endtask

  task automatic drain4();
    int k;
    k = 0;
    while (sb_q.size() != 0 && k < 300) begin
      @(negedge clk);
      k++;
    end
    chk("drain", sb_q.size(), 0);
  endtask

  task automatic conv2(input int v);
    logic [39:0] b;
    logic [9:0]  bl;
    logic        o;
    int          k;
    ref_model(v, 2, b, bl, o);
    k = 0;
    while (!in_ready2 && k < 50) begin
      @(negedge clk);
      k++;
    end
    in_valid2 = 1'b1;
    bin_in2   = 9'(v);
    @(negedge clk);
    in_valid2 = 1'b0;
    bin_in2   = 9'($urandom);
    k = 0;
    while (!out_valid2 && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk($sformatf("d2_latency_%0d", v), k, BIN_W);
    chk($sformatf("d2_bcd_%0d", v), bcd2, b[7:0]);
    chk($sformatf("d2_blank_%0d", v), blank2, bl[1:0]);
    chk($sformatf("d2_ovf_%0d", v), ovf2, o);
    chk($sformatf("d2_busy_%0d", v), busy2, 1'b1);
    @(negedge clk);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_in_ready"}, in_ready4, 1'b1);
    chk({tag, "_out_valid"}, out_valid4, 1'b0);
    chk({tag, "_busy"}, busy4, 1'b0);
    chk({tag, "_bcd"}, bcd4, 16'h0000);
    chk({tag, "_blank"}, blank4, 4'b0000);
    chk({tag, "_ovf"}, ovf4, 1'b0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    chk("reset_d2_bcd", bcd2, 8'h00);

    // First acceptance on the first edge with reset released.
    rst_n = 1'b1;
    rdy_mode = 1;
    send4(0);
    send4(511);
    send4(100);
    send4(7);
    drain4();

    conv2(99);
    conv2(100);
    conv2(0);
    conv2(5);
    conv2(511);

    // Backpressure: hold result for 20 cycles with an ignored second request.
    rdy_mode = 0;
    send4(123);
    for (int k = 0; k < 30 && !out_valid4; k++) @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      chk("bp_out_valid", out_valid4, 1'b1);
      chk("bp_bcd", bcd4, 16'h0123);
      chk("bp_blank", blank4, 4'b1000);
      chk("bp_ovf", ovf4, 1'b0);
      chk("bp_in_ready", in_ready4, 1'b0);
      chk("bp_busy", busy4, 1'b1);
      in_valid4 = 1'b1;
      bin_in4   = 9'd5;
      @(negedge clk);
    end
    in_valid4 = 1'b0;
    rdy_mode  = 1;
    @(negedge clk);
    chk("bp_release_out_valid", out_valid4, 1'b0);
    chk("bp_release_in_ready", in_ready4, 1'b1);
    chk("bp_release_busy", busy4, 1'b0);
    repeat (15) @(negedge clk);
    chk("bp_no_extra", sb_q.size(), 0);

    // Reset in the 4th SHIFT cycle aborts the conversion.
    send4(300);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    sb_q.delete();
    @(negedge clk);
    chk_reset_vals("abort");
    rst_n = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      chk("abort_no_out_valid", out_valid4, 1'b0);
    end
    send4(42);
    drain4();

    stream4(6);
    drain4();

    // All inputs with random gaps and random out_ready.
    rdy_mode = 2;
    for (int v = 0; v < 512; v++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      send4(v);
    end
    drain4();
    rdy_mode = 1;
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
